// File: rtl/arm_pipeline_core.sv
// Five-stage skeleton pipeline (IF, ID, EXE, MEM, WB) that carries fetch PC and instruction word to WB.
// Optional ARM_FREEZE_EN adds a freeze input that stalls PC and IF/ID and injects bubbles into ID/EXE.
module arm_pipeline_core #(
    parameter int          IMEM_DEPTH = 16,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ARM_FREEZE_EN
    input  logic        freeze,
`endif
    output logic [31:0] wb_pc,
    output logic [31:0] wb_instruction,
    output logic        wb_valid
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } stage_t;

    localparam logic [31:0] DEPTH_W  = IMEM_DEPTH;
    localparam logic [31:0] ROM_BASE = 32'hE3A0_0000;

    logic [31:0] pc;
    logic [31:0] rom_index;
    logic [31:0] fetch_word;
    logic        hold;
    stage_t      if_id;
    stage_t      id_exe;
    stage_t      exe_mem;
    stage_t      mem_wb;

`ifdef ARM_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    // ROM contents are generated from the word index; addresses past the ROM fetch zero
    assign rom_index = {2'b00, pc[31:2]};

    always_comb begin
        fetch_word = 32'h0000_0000;
        if (rom_index < DEPTH_W) begin
            fetch_word = ROM_BASE | rom_index;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= PC_RESET;
            if_id   <= '0;
            id_exe  <= '0;
            exe_mem <= '0;
            mem_wb  <= '0;
        end else begin
            if (!hold) begin
                pc     <= pc + 32'd4;
                if_id  <= {1'b1, pc, fetch_word};
                id_exe <= if_id;
            end else begin
                id_exe <= '0;
            end
            exe_mem <= id_exe;
            mem_wb  <= exe_mem;
        end
    end

    assign wb_pc          = mem_wb.pc;
    assign wb_instruction = mem_wb.instr;
    assign wb_valid       = mem_wb.valid;

endmodule

// File: tb/tb_arm_pipeline_core.sv
// Directed bench for arm_pipeline_core: reset, fill latency, async reset, ROM boundary, PC_RESET.
// Freeze scenario is included only when ARM_FREEZE_EN is defined.
module tb_arm_pipeline_core;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [31:0] wb_pc;
    logic [31:0] wb_instruction;
    logic        wb_valid;
    logic [31:0] wb_pc2;
    logic [31:0] wb_instruction2;
    logic        wb_valid2;

    int errors = 0;
    int checks = 0;

    arm_pipeline_core #(.IMEM_DEPTH(16), .PC_RESET(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ARM_FREEZE_EN
        .freeze         (freeze),
`endif
        .wb_pc          (wb_pc),
        .wb_instruction (wb_instruction),
        .wb_valid       (wb_valid)
    );

    arm_pipeline_core #(.IMEM_DEPTH(16), .PC_RESET(32'h0000_0010)) dut2 (
        .clk            (clk),
        .rst            (rst),
`ifdef ARM_FREEZE_EN
        .freeze         (freeze),
`endif
        .wb_pc          (wb_pc2),
        .wb_instruction (wb_instruction2),
        .wb_valid       (wb_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ROM word for a fetch address with a 16-word ROM
    function automatic logic [31:0] exp_instr(input logic [31:0] p);
        logic [31:0] idx;
        idx = p >> 2;
        return (idx < 32'd16) ? (32'hE3A0_0000 | idx) : 32'h0000_0000;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        freeze = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if ({wb_valid, wb_pc, wb_instruction} !== 65'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got valid=%b pc=%h instr=%h, need 0/0/0",
                         wb_valid, wb_pc, wb_instruction);
            end
            checks++;
            if (dut.pc !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_pc: got %h, need 00000000", dut.pc);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency();
        logic [31:0] ep;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e < 4) begin
                if (wb_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL latency_bubble edge %0d: got valid=%b, need 0", e, wb_valid);
                end
            end else begin
                ep = 32'(4 * (e - 4));
                if ({wb_valid, wb_pc, wb_instruction} !== {1'b1, ep, exp_instr(ep)}) begin
                    errors++;
                    $display("[TB] FAIL latency edge %0d: got valid=%b pc=%h instr=%h, need 1 %h %h",
                             e, wb_valid, wb_pc, wb_instruction, ep, exp_instr(ep));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] ep;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_pc, wb_instruction} !== 65'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid=%b pc=%h instr=%h, need 0/0/0",
                     wb_valid, wb_pc, wb_instruction);
        end
        checks++;
        if (dut.pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_pc: got %h, need 00000000", dut.pc);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e < 4) begin
                if (wb_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL restart_bubble edge %0d: got valid=%b, need 0", e, wb_valid);
                end
            end else begin
                ep = 32'(4 * (e - 4));
                if ({wb_valid, wb_pc, wb_instruction} !== {1'b1, ep, exp_instr(ep)}) begin
                    errors++;
                    $display("[TB] FAIL restart edge %0d: got valid=%b pc=%h instr=%h, need 1 %h %h",
                             e, wb_valid, wb_pc, wb_instruction, ep, exp_instr(ep));
                end
            end
        end
    endtask

    task automatic test_rom_boundary();
        logic [31:0] ep;
        pulse_reset();
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk);
            #1;
            if (e >= 18) begin
                ep = 32'(4 * (e - 4));
                checks++;
                if ({wb_valid, wb_pc, wb_instruction} !== {1'b1, ep, exp_instr(ep)}) begin
                    errors++;
                    $display("[TB] FAIL rom_boundary edge %0d: got valid=%b pc=%h instr=%h, need 1 %h %h",
                             e, wb_valid, wb_pc, wb_instruction, ep, exp_instr(ep));
                end
            end
        end
    endtask

    task automatic test_pc_reset();
        logic [31:0] ep;
        pulse_reset();
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e < 4) begin
                if (wb_valid2 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pc_reset_bubble edge %0d: got valid=%b, need 0", e, wb_valid2);
                end
            end else begin
                ep = 32'h10 + 32'(4 * (e - 4));
                if ({wb_valid2, wb_pc2, wb_instruction2} !== {1'b1, ep, exp_instr(ep)}) begin
                    errors++;
                    $display("[TB] FAIL pc_reset edge %0d: got valid=%b pc=%h instr=%h, need 1 %h %h",
                             e, wb_valid2, wb_pc2, wb_instruction2, ep, exp_instr(ep));
                end
            end
        end
    endtask

`ifdef ARM_FREEZE_EN
    task automatic test_freeze();
        logic        ev [1:9];
        logic [31:0] epc[1:9];
        ev  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        epc = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd8, 32'd12};
        pulse_reset();
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ev[e]) begin
                if ({wb_valid, wb_pc, wb_instruction} !== {1'b1, epc[e], exp_instr(epc[e])}) begin
                    errors++;
                    $display("[TB] FAIL freeze edge %0d: got valid=%b pc=%h instr=%h, need 1 %h %h",
                             e, wb_valid, wb_pc, wb_instruction, epc[e], exp_instr(epc[e]));
                end
            end else if ({wb_valid, wb_pc, wb_instruction} !== 65'd0) begin
                errors++;
                $display("[TB] FAIL freeze_bubble edge %0d: got valid=%b pc=%h instr=%h, need 0/0/0",
                         e, wb_valid, wb_pc, wb_instruction);
            end
            if (e == 3) begin
                @(negedge clk);
                freeze = 1'b1;
            end
            if (e == 5) begin
                @(negedge clk);
                freeze = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_async_reset();
        test_rom_boundary();
        test_pc_reset();
`ifdef ARM_FREEZE_EN
        test_freeze();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
